// File: rtl/sram_ctrl_if.sv
// Request/acknowledge port between the core's 32-bit data-memory master and sram_ctrl.
// The master drives the request fields; the controller returns data, ack and busy.
interface sram_ctrl_if;
  logic        i_req;
  logic        i_we;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  i_bmask;
  logic [31:0] o_rdata;
  logic        o_ack;
  logic        o_busy;

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_bmask,
    input  o_rdata, o_ack, o_busy
  );

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_bmask,
    output o_rdata, o_ack, o_busy
  );
endinterface

// File: rtl/sram_ctrl.sv
// 32-bit request port to 256K x 16 asynchronous SRAM bridge: every word access runs as
// a low half-word phase then a high half-word phase, each WAIT_CYCLES long; empty write halves are skipped.
module sram_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  sram_ctrl_if.slave  bus,
  output logic [17:0] o_sram_addr,
  inout  wire  [15:0] io_sram_dq,
  output logic        o_sram_ce_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_we_n,
  output logic        o_sram_lb_n,
  output logic        o_sram_ub_n
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [16:0] wa_q, wa_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  bmask_q, bmask_d;
  logic [15:0] rlo_q, rlo_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d, busy_q, busy_d;
  logic [17:0] addr_q, addr_d;
  logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, lb_n_q, lb_n_d, ub_n_q, ub_n_d;
  logic        dq_oe_q, dq_oe_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        accept_s, last_s, hi_s;

  assign accept_s = (state_q == IDLE) && bus.i_req;
  assign last_s   = (cnt_q == LAST);

  // Operand latch and next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    wa_d    = wa_q;
    wdata_d = wdata_q;
    bmask_d = bmask_q;
    rlo_d   = rlo_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          we_d    = bus.i_we;
          wa_d    = bus.i_addr[18:2];
          wdata_d = bus.i_wdata;
          bmask_d = bus.i_bmask;
          cnt_d   = '0;
          if (bus.i_we && (bus.i_bmask == 4'b0000)) begin
            state_d = DONE;
          end else if (bus.i_we && (bus.i_bmask[1:0] == 2'b00)) begin
            state_d = HI;
          end else begin
            state_d = LO;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LO: begin
        if (last_s) begin
          cnt_d = '0;
          if (!we_q) begin
            rlo_d = io_sram_dq;
          end else begin
            rlo_d = rlo_q;
          end
          if (we_q && (bmask_q[3:2] == 2'b00)) begin
            state_d = DONE;
          end else begin
            state_d = HI;
          end
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      HI: begin
        if (last_s) begin
          cnt_d   = '0;
          state_d = DONE;
          if (!we_q) begin
            rdata_d = {io_sram_dq, rlo_q};
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values for the cycle being entered; we_n releases one cycle early for hold time
  always_comb begin
    hi_s     = (state_d == HI);
    ack_d    = 1'b0;
    busy_d   = (state_d != IDLE);
    addr_d   = addr_q;
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    lb_n_d   = 1'b1;
    ub_n_d   = 1'b1;
    dq_oe_d  = 1'b0;
    dq_out_d = dq_out_q;
    case (state_d)
      LO, HI: begin
        addr_d = {wa_d, hi_s};
        ce_n_d = 1'b0;
        if (we_d) begin
          lb_n_d   = hi_s ? ~bmask_d[2] : ~bmask_d[0];
          ub_n_d   = hi_s ? ~bmask_d[3] : ~bmask_d[1];
          dq_oe_d  = 1'b1;
          dq_out_d = hi_s ? wdata_d[31:16] : wdata_d[15:0];
          we_n_d   = (cnt_d == LAST);
        end else begin
          oe_n_d = 1'b0;
          lb_n_d = 1'b0;
          ub_n_d = 1'b0;
        end
      end
      DONE: begin
        ack_d = 1'b1;
      end
      IDLE: begin
        ack_d = 1'b0;
      end
      default: begin
        ack_d = 1'b0;
      end
    endcase
  end

  // State, operand and registered-output flops
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      wa_q     <= 17'd0;
      wdata_q  <= 32'd0;
      bmask_q  <= 4'd0;
      rlo_q    <= 16'd0;
      rdata_q  <= 32'd0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      addr_q   <= 18'd0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      dq_out_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wdata_q  <= wdata_d;
      bmask_q  <= bmask_d;
      rlo_q    <= rlo_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      lb_n_q   <= lb_n_d;
      ub_n_q   <= ub_n_d;
      dq_oe_q  <= dq_oe_d;
      dq_out_q <= dq_out_d;
    end
  end

  assign io_sram_dq  = dq_oe_q ? dq_out_q : {16{1'bz}};
  assign o_sram_addr = addr_q;
  assign o_sram_ce_n = ce_n_q;
  assign o_sram_oe_n = oe_n_q;
  assign o_sram_we_n = we_n_q;
  assign o_sram_lb_n = lb_n_q;
  assign o_sram_ub_n = ub_n_q;
  assign bus.o_rdata = rdata_q;
  assign bus.o_ack   = ack_q;
  assign bus.o_busy  = busy_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl against a behavioural 256K x 16 SRAM model.
module tb_sram_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_ctrl_if bus();
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic ce_n, oe_n, we_n, lb_n, ub_n;

  sram_ctrl #(.WAIT_CYCLES(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
    .o_sram_addr(sram_addr), .io_sram_dq(sram_dq),
    .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
    .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
  );

  logic [15:0] mem [0:262143];
  int we_low_cnt = 0;
  logic last_lb = 1'b1, last_ub = 1'b1;
  logic [17:0] last_waddr = 18'd0;

  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : {16{1'bz}};

  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) mem[sram_addr][7:0]  <= sram_dq[7:0];
      if (!ub_n) mem[sram_addr][15:8] <= sram_dq[15:8];
      we_low_cnt <= we_low_cnt + 1;
      last_lb    <= lb_n;
      last_ub    <= ub_n;
      last_waddr <= sram_addr;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: measures latency from busy rise and pops the scoreboard on every ack
  int   cyc = 0;
  int   acc_cyc = 0;
  logic busy_prev = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      busy_prev = 1'b0;
    end else begin
      if (bus.o_busy && !busy_prev) acc_cyc = cyc;
      busy_prev = bus.o_busy;
      if (bus.o_ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ack_latency", cyc - acc_cyc + 1, e.lat);
          chk("rdata", bus.o_rdata, e.rdata);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] bmask);
    bus.i_req   = 1'b1;
    bus.i_we    = we;
    bus.i_addr  = addr;
    bus.i_wdata = wdata;
    bus.i_bmask = bmask;
  endtask

  task automatic wait_ack(input bit scramble);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.o_ack) begin
        got = 1'b1;
      end else if (scramble && bus.o_busy) begin
        bus.i_req   = 1'($urandom_range(1, 0));
        bus.i_we    = 1'($urandom_range(1, 0));
        bus.i_addr  = $urandom;
        bus.i_wdata = $urandom;
        bus.i_bmask = 4'($urandom_range(15, 0));
      end
    end
    if (!got) begin
      chk("ack_timeout", 32'd0, 32'd1);
      if (sb.size() != 0) void'(sb.pop_back());
    end
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] bmask, input logic [31:0] exp_rd, input int lat,
                        input bit scramble);
    sb.push_back('{exp_rd, lat});
    @(posedge clk); #1;
    issue(we, addr, wdata, bmask);
    wait_ack(scramble);
    bus.i_req = 1'b0;
    @(posedge clk); #1;
  endtask

  int wl0;

  initial begin
    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_addr = 32'd0; bus.i_wdata = 32'd0; bus.i_bmask = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
    chk("rst_busy_ack", {30'd0, bus.o_busy, bus.o_ack}, 32'd0);
    chk("rst_rdata", bus.o_rdata, 32'd0);
    chk("rst_addr", {14'd0, sram_addr}, 32'd0);
    chk("rst_dq_oe", {31'd0, dut.dq_oe_q}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Full-word write then read
    wl0 = we_low_cnt;
    access(1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, 32'h0, 5, 1'b0);
    chk("mem_80", {16'd0, mem[18'h80]}, 32'h0000BEEF);
    chk("mem_81", {16'd0, mem[18'h81]}, 32'h0000DEAD);
    chk("full_we_pulses", we_low_cnt - wl0, 32'd2);
    access(1'b0, 32'h100, 32'h0, 4'b1111, 32'hDEADBEEF, 5, 1'b0);

    // Byte write: low phase only, upper lane of low half
    wl0 = we_low_cnt;
    access(1'b1, 32'h100, 32'h0000AA00, 4'b0010, 32'hDEADBEEF, 3, 1'b0);
    chk("byte_we_pulses", we_low_cnt - wl0, 32'd1);
    chk("byte_lanes", {30'd0, last_lb, last_ub}, 32'd2);
    chk("byte_waddr", {14'd0, last_waddr}, 32'h80);
    access(1'b0, 32'h100, 32'h0, 4'b1111, 32'hDEADAAEF, 5, 1'b0);

    // Empty mask and address wrap
    wl0 = we_low_cnt;
    access(1'b1, 32'h104, 32'hFFFFFFFF, 4'b0000, 32'hDEADAAEF, 1, 1'b0);
    chk("empty_we_pulses", we_low_cnt - wl0, 32'd0);
    access(1'b1, 32'h0008_0000, 32'h12345678, 4'b1111, 32'hDEADAAEF, 5, 1'b0);
    chk("wrap_mem0", {16'd0, mem[18'h0]}, 32'h00005678);
    chk("wrap_mem1", {16'd0, mem[18'h1]}, 32'h00001234);
    access(1'b0, 32'h0, 32'h0, 4'b1111, 32'h12345678, 5, 1'b0);

    // Operands scrambled while busy
    access(1'b1, 32'h200, 32'hCAFEF00D, 4'b1111, 32'h12345678, 5, 1'b1);
    chk("scr_mem100", {16'd0, mem[18'h100]}, 32'h0000F00D);
    chk("scr_mem101", {16'd0, mem[18'h101]}, 32'h0000CAFE);

    // Back-to-back: high-only write held across ack, then read
    sb.push_back('{32'h12345678, 3});
    sb.push_back('{32'h0BADF00D, 5});
    @(posedge clk); #1;
    issue(1'b1, 32'h200, 32'h0BADC0DE, 4'b1100);
    wait_ack(1'b0);
    issue(1'b0, 32'h200, 32'h0, 4'b1111);
    @(posedge clk); #1;
    chk("b2b_idle_gap", {31'd0, bus.o_busy}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_accept", {31'd0, bus.o_busy}, 32'd1);
    wait_ack(1'b0);
    bus.i_req = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a write pulse
    issue(1'b1, 32'h400, 32'h11112222, 4'b1111);
    for (int i = 0; i < 20 && we_n; i++) begin
      @(posedge clk); #1;
    end
    chk("mid_we_low", {31'd0, we_n}, 32'd0);
    rst_n = 1'b0;
    bus.i_req = 1'b0;
    #1;
    chk("mid_rst_strobes", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
    chk("mid_rst_dq_oe", {31'd0, dut.dq_oe_q}, 32'd0);
    chk("mid_rst_busy_ack", {30'd0, bus.o_busy, bus.o_ack}, 32'd0);
    chk("mid_rst_rdata", bus.o_rdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_busy_ack", {30'd0, bus.o_busy, bus.o_ack}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
